fp_adder_arbiter: RTL and testbench

Shares the single FP adder/subtractor between two requesters: port 0 (top-level add/sub path) and port 1 (FP_Divider Newton-Raphson steps).
Each request is latched on a load pulse, arbitrated round-robin, and issued to the adder with a one-cycle load.
The adder result is routed back to the owning port with a held valid level, matching the adder handshake the divider already expects.
A watchdog aborts transactions the adder never completes.

---
 rtl/fp_adder_arbiter.sv | 120 ++++++++++++
 tb/tb_fp_adder_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: round-robin sharing of one FP adder between two latched requesters, with a watchdog
module fp_adder_arbiter #(
  parameter int PRECISION = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [PRECISION-1:0] Req0A,
  input  logic [PRECISION-1:0] Req0B,
  input  logic                 Req0Op,
  input  logic                 Req0Load,
  output logic [PRECISION-1:0] Resp0Out,
  output logic                 Resp0Valid,
  input  logic [PRECISION-1:0] Req1A,
  input  logic [PRECISION-1:0] Req1B,
  input  logic                 Req1Op,
  input  logic                 Req1Load,
  output logic [PRECISION-1:0] Resp1Out,
  output logic                 Resp1Valid,
  output logic [PRECISION-1:0] AddA,
  output logic [PRECISION-1:0] AddB,
  output logic                 AddOp,
  output logic                 AddLoad,
  input  logic                 AddValid,
  input  logic [PRECISION-1:0] AddOut,
  output logic                 Busy,
  output logic                 Grant,
  output logic                 TimeoutErr
);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT_LOW = 3'd2, WAIT_HIGH = 3'd3, DONE = 3'd4;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [2:0] state;
  logic [CW-1:0] wdCnt;
  logic pend0, pend1, lastGrant, slot0Op, slot1Op, gSel, timeoutHit;
  logic [PRECISION-1:0] slot0A, slot0B, slot1A, slot1B;
  always_comb begin
    gSel = (pend0 && pend1) ? ~lastGrant : pend1;
    timeoutHit = wdCnt >= CW'(TIMEOUT - 1);
    AddLoad = state == ISSUE;
    Busy = state != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      wdCnt <= '0;
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      lastGrant <= 1'b1;
      Grant <= 1'b0;
      TimeoutErr <= 1'b0;
      AddA <= '0;
      AddB <= '0;
      AddOp <= 1'b0;
      Resp0Out <= '0;
      Resp1Out <= '0;
      Resp0Valid <= 1'b0;
      Resp1Valid <= 1'b0;
      slot0A <= '0;
      slot0B <= '0;
      slot0Op <= 1'b0;
      slot1A <= '0;
      slot1B <= '0;
      slot1Op <= 1'b0;
    end else begin
      TimeoutErr <= 1'b0;
      case (state)
        IDLE: if (pend0 || pend1) begin
          state <= ISSUE;
          Grant <= gSel;
          lastGrant <= gSel;
          AddA <= gSel ? slot1A : slot0A;
          AddB <= gSel ? slot1B : slot0B;
          AddOp <= gSel ? slot1Op : slot0Op;
          if (gSel) pend1 <= 1'b0;
          else pend0 <= 1'b0;
        end
        ISSUE: begin
          state <= WAIT_LOW;
          wdCnt <= '0;
        end
        WAIT_LOW, WAIT_HIGH: begin
          wdCnt <= wdCnt + CW'(1);
          // progress wins over the watchdog so a result on the final cycle is kept
          if (state == WAIT_LOW && !AddValid) state <= WAIT_HIGH;
          else if (state == WAIT_HIGH && AddValid) state <= DONE;
          else if (timeoutHit) begin
            state <= IDLE;
            TimeoutErr <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (Grant) begin
            Resp1Out <= AddOut;
            Resp1Valid <= !pend1;
          end else begin
            Resp0Out <= AddOut;
            Resp0Valid <= !pend0;
          end
        end
        default: state <= IDLE;
      endcase
      // captures come last so a same-edge load beats the grant clear and the DONE valid
      if (Req0Load) begin
        slot0A <= Req0A;
        slot0B <= Req0B;
        slot0Op <= Req0Op;
        pend0 <= 1'b1;
        Resp0Valid <= 1'b0;
      end
      if (Req1Load) begin
        slot1A <= Req1A;
        slot1B <= Req1B;
        slot1Op <= Req1Op;
        pend1 <= 1'b1;
        Resp1Valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// tb_fp_adder_arbiter: scoreboard bench with a behavioural FP adder and per-port expected-result queues
module tb_fp_adder_arbiter;
  localparam int TO = 64;
  logic Clk = 0, Rst = 1;
  logic [31:0] Req0A = 0, Req0B = 0, Req1A = 0, Req1B = 0, Resp0Out, Resp1Out, AddA, AddB, AddOut;
  logic Req0Op = 0, Req0Load = 0, Req1Op = 0, Req1Load = 0, Resp0Valid, Resp1Valid;
  logic AddOp, AddLoad, AddValid, Busy, Grant, TimeoutErr;
  int tests = 0, fails = 0, respCnt0 = 0, respCnt1 = 0, lat = 3;
  bit hang = 0;
  logic [31:0] q0[$], q1[$];
  logic grantLog[$];

  fp_adder_arbiter #(.PRECISION(32), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0A(Req0A), .Req0B(Req0B), .Req0Op(Req0Op), .Req0Load(Req0Load), .Resp0Out(Resp0Out), .Resp0Valid(Resp0Valid),
    .Req1A(Req1A), .Req1B(Req1B), .Req1Op(Req1Op), .Req1Load(Req1Load), .Resp1Out(Resp1Out), .Resp1Valid(Resp1Valid),
    .AddA(AddA), .AddB(AddB), .AddOp(AddOp), .AddLoad(AddLoad), .AddValid(AddValid), .AddOut(AddOut),
    .Busy(Busy), .Grant(Grant), .TimeoutErr(TimeoutErr)
  );

  always #5 Clk = ~Clk;

  function automatic real f2r(logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rem;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    m = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 1;
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] fpAdd(logic [31:0] a, logic [31:0] b, logic op);
    return r2f(op ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] randF();
    return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // adder model: drops valid when started, raises it with the sum after a latency
  initial begin
    logic [31:0] r;
    int l;
    AddValid = 0;
    AddOut = 0;
    forever begin
      @(negedge Clk);
      if (AddLoad === 1'b1) begin
        r = fpAdd(AddA, AddB, AddOp);
        l = lat != 0 ? lat : int'($urandom_range(5, 2));
        AddValid = 0;
        if (!hang) begin
          repeat (l) @(negedge Clk);
          AddOut = r;
          AddValid = 1;
        end
      end
    end
  end

  initial begin
    logic p0, p1;
    p0 = 0;
    p1 = 0;
    forever begin
      @(negedge Clk);
      if (AddLoad === 1'b1) grantLog.push_back(Grant);
      if (Resp0Valid && !p0) begin
        respCnt0++;
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL resp0 unexpected: got valid with %h, expected no response", Resp0Out);
        end else check("resp0 value", Resp0Out, q0.pop_front());
      end
      if (Resp1Valid && !p1) begin
        respCnt1++;
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL resp1 unexpected: got valid with %h, expected no response", Resp1Out);
        end else check("resp1 value", Resp1Out, q1.pop_front());
      end
      p0 = Resp0Valid;
      p1 = Resp1Valid;
    end
  end

  task automatic load(int port, logic [31:0] a, logic [31:0] b, logic op, bit push);
    if (port == 0) begin
      Req0A = a; Req0B = b; Req0Op = op; Req0Load = 1;
      if (push) q0.push_back(fpAdd(a, b, op));
    end else begin
      Req1A = a; Req1B = b; Req1Op = op; Req1Load = 1;
      if (push) q1.push_back(fpAdd(a, b, op));
    end
    @(negedge Clk);
    if (port == 0) Req0Load = 0;
    else Req1Load = 0;
  endtask

  task automatic drain(int maxc);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    check("drain outstanding", 32'(q0.size() + q1.size()), 0);
  endtask

  task automatic waitResp(int port, int maxc);
    int c0 = port != 0 ? respCnt1 : respCnt0;
    int n = 0;
    while ((port != 0 ? respCnt1 : respCnt0) == c0 && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    check("response arrived", 32'(n < maxc), 1);
  endtask

  task automatic waitAddLoad(int maxc);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (AddLoad !== 1'b1 && n < maxc);
    check("AddLoad seen", 32'(AddLoad), 1);
  endtask

  initial begin
    int n, alt;
    logic [31:0] e1;
    bit bad;
    repeat (3) @(negedge Clk);
    check("reset flags", {Resp0Valid, Resp1Valid, AddLoad, Busy, Grant, TimeoutErr, AddOp}, 0);
    check("reset resp0", Resp0Out, 0);
    check("reset resp1", Resp1Out, 0);
    check("reset AddA", AddA, 0);
    check("reset AddB", AddB, 0);
    Rst = 0;
    // port 1 alone: 1.5 + -0.5
    @(negedge Clk);
    load(1, 32'h3FC00000, 32'hBF000000, 0, 1);
    check("addload early", 32'(AddLoad), 0);
    @(negedge Clk);
    check("addload 2 cycles", 32'(AddLoad), 1);
    check("grant port1", 32'(Grant), 1);
    drain(50);
    repeat (5) @(negedge Clk);
    check("resp1 held valid", 32'(Resp1Valid), 1);
    check("resp1 is 1.0", Resp1Out, 32'h3F800000);
    check("resp0 untouched", 32'(Resp0Valid), 0);
    load(1, 32'h40000000, 32'h40000000, 0, 1);
    check("resp1 cleared by load", 32'(Resp1Valid), 0);
    drain(50);
    // simultaneous loads from reset
    Rst = 1;
    @(negedge Clk);
    Rst = 0;
    grantLog.delete();
    fork
      load(0, r2f(3.14), r2f(0.02), 1, 1);
      load(1, r2f(0.2), r2f(500.0), 0, 1);
    join
    drain(100);
    check("simul addloads", 32'(grantLog.size()), 2);
    if (grantLog.size() == 2) begin
      check("simul first grant", 32'(grantLog[0]), 0);
      check("simul second grant", 32'(grantLog[1]), 1);
    end
    // both ports requesting continuously with random operands and latency
    lat = 0;
    grantLog.delete();
    fork
      for (int i = 0; i < 10; i++) begin
        load(0, randF(), randF(), 1'($urandom), 1);
        waitResp(0, 300);
      end
      for (int j = 0; j < 10; j++) begin
        load(1, randF(), randF(), 1'($urandom), 1);
        waitResp(1, 300);
      end
    join
    drain(100);
    check("contention grants", 32'(grantLog.size()), 20);
    alt = 0;
    for (int k = 1; k < grantLog.size(); k++) if (grantLog[k] == grantLog[k-1]) alt++;
    check("grant alternation repeats", 32'(alt), 0);
    // watchdog
    lat = 3;
    hang = 1;
    load(0, randF(), randF(), 0, 0);
    waitAddLoad(10);
    n = 0;
    while (TimeoutErr !== 1'b1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("timeout latency", 32'(n), TO + 1);
    check("busy after timeout", 32'(Busy), 0);
    check("no valid on timeout", 32'(Resp0Valid), 0);
    @(negedge Clk);
    check("timeout one pulse", 32'(TimeoutErr), 0);
    hang = 0;
    load(0, randF(), randF(), 1, 1);
    drain(50);
    // reset in WAIT_HIGH with port 0 pending
    lat = 6;
    load(1, randF(), randF(), 0, 0);
    waitAddLoad(10);
    load(0, randF(), randF(), 0, 0);
    @(negedge Clk);
    Rst = 1;
    @(negedge Clk);
    Rst = 0;
    check("rst flags", {Resp0Valid, Resp1Valid, AddLoad, Busy, Grant, TimeoutErr, AddOp}, 0);
    check("rst resp0", Resp0Out, 0);
    check("rst resp1", Resp1Out, 0);
    check("rst AddA", AddA, 0);
    check("rst AddB", AddB, 0);
    bad = 0;
    repeat (12) begin
      @(negedge Clk);
      if (AddLoad || Resp0Valid || Resp1Valid || Busy) bad = 1;
    end
    check("quiet after rst", 32'(bad), 0);
    // reload on port 1 while its transaction is in flight
    lat = 3;
    Req1A = randF();
    Req1B = randF();
    e1 = fpAdd(Req1A, Req1B, 0);
    load(1, Req1A, Req1B, 0, 0);
    waitAddLoad(10);
    load(1, 32'h40000000, 32'h40000000, 0, 1);
    waitAddLoad(30);
    check("first result landed", Resp1Out, e1);
    check("first result not valid", 32'(Resp1Valid), 0);
    drain(50);
    check("second result is 4.0", Resp1Out, 32'h40800000);
    repeat (3) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
